mul_approx_seq: RTL and testbench
=================================

MUL_APPROX_SEQ -- requirements
Module: mul_approx_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal 2..16).
REQ-002 The block SHALL have parameter TRUNC, default 2, giving the number of low product columns whose partial-product bits are dropped (legal 0..WIDTH).
REQ-003 The block SHALL have parameter ET, default 5, giving the absolute error threshold, 2*WIDTH bits wide.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-008 The block SHALL have port a, input, WIDTH bits: multiplicand, unsigned.
REQ-009 The block SHALL have port b, input, WIDTH bits: multiplier, unsigned.
REQ-010 The block SHALL have port approx_en, input, 1 bit: 1 selects truncated product, 0 selects exact product.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-013 The block SHALL have port prod, output, 2*WIDTH bits: result.
REQ-014 The block SHALL have port err_flag, output, 1 bit: absolute error of the current result exceeds ET.
REQ-015 The block SHALL have port err_cnt, output, 16 bits: count of results with err_flag set.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, MUL and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 On an edge in IDLE with in_valid=1, the block SHALL capture a, b and approx_en, clear the accumulator and the iteration counter, and enter MUL.
REQ-018 In MUL, iteration i (0..WIDTH-1) SHALL take one cycle and add b[i] * ((a<<i) AND mask) to the 2*WIDTH-bit accumulator; the add never overflows.
REQ-019 The mask SHALL zero bit positions below TRUNC when the captured approx_en=1, and SHALL be all ones otherwise.
REQ-020 After iteration WIDTH-1 the block SHALL enter DONE, so out_valid rises exactly WIDTH+1 edges after the accepting edge.
REQ-021 prod, err_flag and err_cnt SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 On an edge in DONE with out_ready=1, the block SHALL return to IDLE; a new operand pair cannot be accepted on that same edge.
REQ-023 in_valid SHALL be ignored outside IDLE; a, b and approx_en changes during MUL or DONE SHALL NOT affect the result.
REQ-024 TRUNC=0, or approx_en=0, SHALL yield the exact product a*b.

Reset
REQ-025 While rst=1 at an edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, prod=0, err_flag=0, err_cnt=0 and accumulator=0.
REQ-026 rst asserted during MUL or DONE SHALL abort the operation; no out_valid is produced for the aborted pair.
REQ-027 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-028 With macro MUL_ERR_MON_EN defined, the block SHALL compute the exact product of the captured operands, set err_flag = (|exact - prod| > ET) on the edge entering DONE, and increment err_cnt on that edge when err_flag is set, saturating at 65535.
REQ-029 Without MUL_ERR_MON_EN, the block SHALL contain no exact-product or error logic, and err_flag and err_cnt SHALL be tied to 0; ports and timing SHALL be unchanged.

Verification
REQ-030 Test V1: WIDTH=4, TRUNC=2, approx_en=1, a=15, b=15 -> prod=220, out_valid 5 edges after accept, err_flag=0 (error 5 is not greater than 5).
REQ-031 Test V2: same operands with approx_en=0 -> prod=225, err_flag=0; then a=7, b=3, approx_en=1 -> prod=16.
REQ-032 Test V3: TRUNC=3, a=15, b=15, approx_en=1, MUL_ERR_MON_EN defined -> prod=208, err_flag=1, err_cnt increments by 1; without the macro, err_flag=0 and err_cnt=0.
REQ-033 Test V4: hold out_ready=0 for 10 cycles while in_valid stays high with new operands -> prod held, in_ready=0; on the out_ready pulse, next accept occurs no earlier than the following edge.
REQ-034 Test V5: assert rst on the 2nd MUL cycle of a=9, b=6 -> next cycle IDLE, out_valid=0, prod=0; a fresh a=3, b=3, approx_en=1 -> prod=4.
REQ-035 Test V6: exhaustive sweep, WIDTH=4, TRUNC=2, all 256 pairs -> prod matches the masked-partial-product model, and max |error|=5 with MUL_ERR_MON_EN.

Source files
------------

// File: rtl/mul_approx_seq.sv
// mul_approx_seq: sequential shift-and-add unsigned multiplier with an
// optional truncated (approximate) mode.
//
// One partial product is accumulated per cycle. When the captured
// approx_en is set, all partial-product bits that fall in product columns
// below TRUNC are dropped.
//
// Optional feature (macro MUL_ERR_MON_EN):
//   - computes the exact product alongside the approximate one
//   - raises err_flag when |exact - prod| > ET
//   - counts flagged results in err_cnt, saturating at 65535
//   Without the macro, err_flag and err_cnt are tied to zero.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  operand pair offered
//   in_ready  high in IDLE only
//   a, b      unsigned operands (WIDTH bits)
//   approx_en 1 = truncated product, 0 = exact product
//   out_valid high in DONE only
//   out_ready consumer takes the result
//   prod      2*WIDTH-bit result
//   err_flag  error of current result exceeds ET (monitor builds only)
//   err_cnt   number of flagged results (monitor builds only)
module mul_approx_seq #(
    parameter int                 WIDTH = 4,
    parameter int                 TRUNC = 2,
    parameter logic [2*WIDTH-1:0] ET    = (2*WIDTH)'(5)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 err_flag,
    output logic [15:0]          err_cnt
);

    localparam int              PW         = 2 * WIDTH;
    localparam int              CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_CNT   = CW'(WIDTH);
    // All ones with the low TRUNC columns cleared.
    localparam logic [PW-1:0]   TRUNC_MASK = {PW{1'b1}} << TRUNC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [PW-1:0]     a_sh_r;       // multiplicand, shifted left each iteration
    logic [WIDTH-1:0]  b_sh_r;       // multiplier, shifted right each iteration
    logic              approx_r;
    logic [PW-1:0]     acc_r;
    logic [CW-1:0]     cnt_r;
    logic [PW-1:0]     prod_r;
    logic [PW-1:0]     mask_s;
    logic [PW-1:0]     pp_s;
    logic              mul_last_s;
    logic              in_ready_s;
    logic              out_valid_s;

    // Iterations 0..WIDTH-1 add partial products; the extra cycle at
    // cnt_r == WIDTH publishes the result and moves to DONE.
    assign mul_last_s = (state_r == MUL) && (cnt_r == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (mul_last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = 1'b1;
            DONE:    out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Current partial product, masked in truncated mode.
    always_comb begin
        if (approx_r) begin
            mask_s = TRUNC_MASK;
        end else begin
            mask_s = {PW{1'b1}};
        end
        if (b_sh_r[0]) begin
            pp_s = a_sh_r & mask_s;
        end else begin
            pp_s = {PW{1'b0}};
        end
    end

    // Operand capture, shift-and-add datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r   <= {PW{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            approx_r <= 1'b0;
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            prod_r   <= {PW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r   <= {{WIDTH{1'b0}}, a};
                        b_sh_r   <= b;
                        approx_r <= approx_en;
                        acc_r    <= {PW{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                MUL: begin
                    if (mul_last_s) begin
                        prod_r <= acc_r;
                    end else begin
                        acc_r  <= acc_r + pp_s;
                        a_sh_r <= a_sh_r << 1;
                        b_sh_r <= b_sh_r >> 1;
                        cnt_r  <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    prod_r <= prod_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign prod      = prod_r;

`ifdef MUL_ERR_MON_EN
    logic [WIDTH-1:0]  a_op_r;
    logic [WIDTH-1:0]  b_op_r;
    logic [PW-1:0]     exact_s;
    logic [PW-1:0]     diff_s;
    logic              err_s;
    logic              err_flag_r;
    logic [15:0]       err_cnt_r;

    // Unshifted copies of the operands for the exact reference product.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_op_r <= {WIDTH{1'b0}};
            b_op_r <= {WIDTH{1'b0}};
        end else if (in_ready_s && in_valid) begin
            a_op_r <= a;
            b_op_r <= b;
        end else begin
            a_op_r <= a_op_r;
            b_op_r <= b_op_r;
        end
    end

    // Absolute distance between exact and accumulated product.
    always_comb begin
        exact_s = {{WIDTH{1'b0}}, a_op_r} * {{WIDTH{1'b0}}, b_op_r};
        if (exact_s >= acc_r) begin
            diff_s = exact_s - acc_r;
        end else begin
            diff_s = acc_r - exact_s;
        end
        err_s = (diff_s > ET);
    end

    // Error flag and saturating counter, updated on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag_r <= 1'b0;
            err_cnt_r  <= 16'd0;
        end else if (mul_last_s) begin
            err_flag_r <= err_s;
            if (err_s && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end else begin
            err_flag_r <= err_flag_r;
        end
    end

    assign err_flag = err_flag_r;
    assign err_cnt  = err_cnt_r;
`else
    logic unused_et_s;
    assign unused_et_s = ^ET;
    assign err_flag    = 1'b0;
    assign err_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_mul_approx_seq.sv
// Self-checking bench for mul_approx_seq. Two instances share all inputs:
// dut2 uses TRUNC=2 and dut3 uses TRUNC=3 (both WIDTH=4, ET=5). Expected
// products come from a column-wise partial-product model.
module tb_mul_approx_seq;

    localparam int W  = 4;
    localparam int PW = 8;
    localparam int ET = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          approx_en;
    logic          in_ready, in_ready3;
    logic          out_valid, out_valid3;
    logic [PW-1:0] prod, prod3;
    logic          err_flag, err_flag3;
    logic [15:0]   err_cnt, err_cnt3;

    int passed = 0;
    int total  = 0;
    int cnt2   = 0;
    int cnt3   = 0;
    int maxerr = 0;

    always #5 clk = ~clk;

    mul_approx_seq #(.WIDTH(W), .TRUNC(2), .ET(8'd5)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid),
        .out_ready(out_ready), .prod(prod), .err_flag(err_flag), .err_cnt(err_cnt)
    );

    mul_approx_seq #(.WIDTH(W), .TRUNC(3), .ET(8'd5)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid3),
        .out_ready(out_ready), .prod(prod3), .err_flag(err_flag3), .err_cnt(err_cnt3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Sum of the bits a[j]&b[i], each weighted 2^(i+j); columns i+j below
    // trunc are skipped in approximate mode.
    function automatic int model(input int x, input int y, input int trunc, input bit ap);
        int s = 0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (((x >> j) & 1) == 1 && ((y >> i) & 1) == 1 && (!ap || (i + j) >= trunc))
                    s += (1 << (i + j));
            end
        end
        return s;
    endfunction

    // Called at the negedge just after the accepting edge.
    task automatic collect(input int x, input int y, input bit ap);
        int lat = 0;
        int e2, e3, p2, p3;
        do begin
            @(posedge clk); lat++; @(negedge clk);
        end while (!out_valid && lat < 20);
        check("latency", 32'(lat), 32'(W + 1));
        check("out_valid3", 32'(out_valid3), 32'd1);
        p2 = model(x, y, 2, ap);
        p3 = model(x, y, 3, ap);
        e2 = x * y - p2;
        e3 = x * y - p3;
        check("prod_t2", 32'(prod), 32'(p2));
        check("prod_t3", 32'(prod3), 32'(p3));
`ifdef MUL_ERR_MON_EN
        if (e2 > ET) cnt2++;
        if (e3 > ET) cnt3++;
        if (e2 > maxerr) maxerr = e2;
        check("err_flag_t2", 32'(err_flag), 32'(e2 > ET));
        check("err_flag_t3", 32'(err_flag3), 32'(e3 > ET));
        check("err_cnt_t2", 32'(err_cnt), 32'(cnt2));
        check("err_cnt_t3", 32'(err_cnt3), 32'(cnt3));
`else
        check("err_flag_off", 32'(err_flag | err_flag3), 32'd0);
        check("err_cnt_off", 32'(err_cnt | err_cnt3), 32'd0);
`endif
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Called at a negedge: offer, wait for acceptance, scramble inputs, check.
    task automatic run_txn(input int x, input int y, input bit ap);
        int guard = 0;
        a = 4'(x); b = 4'(y); approx_en = ap; in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        a = 4'($urandom); b = 4'($urandom); approx_en = ~ap;
        collect(x, y, ap);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 4'd0; b = 4'd0; approx_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready & in_ready3), 32'd1);
        check("rst_out_valid", 32'(out_valid | out_valid3), 32'd0);
        check("rst_prod", 32'(prod | prod3), 32'd0);
        check("rst_err_flag", 32'(err_flag | err_flag3), 32'd0);
        check("rst_err_cnt", 32'(err_cnt | err_cnt3), 32'd0);

        // V1, V2, V3: 15*15 -> 220 (T2), 208 (T3); exact 225; 7*3 -> 16.
        run_txn(15, 15, 1'b1);
        check("v1_prod", 32'(prod), 32'd220);
        check("v3_prod", 32'(prod3), 32'd208);
        run_txn(15, 15, 1'b0);
        check("v2_exact", 32'(prod), 32'd225);
        run_txn(7, 3, 1'b1);
        check("v2_7x3", 32'(prod), 32'd16);

        // V4: back-pressure with in_valid held high and operands changing.
        a = 4'd11; b = 4'd13; approx_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        a = 4'($urandom); b = 4'($urandom);
        collect(11, 13, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            a = 4'($urandom); b = 4'($urandom);
            check("hold_prod", 32'(prod), 32'(model(11, 13, 2, 1'b1)));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        a = 4'd5; b = 4'd6; approx_en = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("no_accept_on_release", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("accept_after_release", 32'(in_ready), 32'd0);
        collect(5, 6, 1'b1);
        drain();

        // V5: reset in the second MUL cycle aborts the operation.
        a = 4'd9; b = 4'd6; approx_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        cnt2 = 0; cnt3 = 0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_prod", 32'(prod), 32'd0);
        check("abort_err_cnt", 32'(err_cnt | err_cnt3), 32'd0);
        seen = 0;
        repeat (W + 3) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_txn(3, 3, 1'b1);
        check("v5_3x3", 32'(prod), 32'd4);

        // V6: exhaustive approximate sweep, then random mode mix.
        maxerr = 0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_txn(x, y, 1'b1);
`ifdef MUL_ERR_MON_EN
        check("max_err_t2", 32'(maxerr), 32'd5);
`endif
        for (int k = 0; k < 30; k++)
            run_txn(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
